// File: rtl/dut_vector_engine_if.sv
// rtl/dut_vector_engine_if.sv - FIFO and DUT-pin bundle for the vector engine
interface dut_vector_engine_if #(
    parameter int STF_WIDTH = 24,
    parameter int RTF_WIDTH = 24,
    parameter int DIF_WIDTH = 32
);
    logic [STF_WIDTH-1:0] sfifo_data;
    logic                 sfifo_rdreq;
    logic                 sfifo_rdempty;
    logic [DIF_WIDTH-1:0] dififo_data;
    logic                 dififo_rdreq;
    logic                 dififo_rdempty;
    logic [RTF_WIDTH-1:0] rfifo_data;
    logic                 rfifo_wrreq;
    logic                 rfifo_wrfull;
    logic [STF_WIDTH-1:0] mosi_data;
    logic [RTF_WIDTH-1:0] miso_data;

    modport master (
        input  sfifo_data, sfifo_rdempty,
        output sfifo_rdreq,
        input  dififo_data, dififo_rdempty,
        output dififo_rdreq,
        output rfifo_data, rfifo_wrreq,
        input  rfifo_wrfull,
        output mosi_data,
        input  miso_data
    );

    modport slave (
        output sfifo_data, sfifo_rdempty,
        input  sfifo_rdreq,
        output dififo_data, dififo_rdempty,
        input  dififo_rdreq,
        input  rfifo_data, rfifo_wrreq,
        output rfifo_wrfull,
        input  mosi_data,
        output miso_data
    );
endinterface

// File: rtl/dut_vector_engine.sv
// rtl/dut_vector_engine.sv - command decoder and stimulus/response burst engine
// Single clock domain; the DUT clock is a register muxed onto selected mosi pins.
module dut_vector_engine #(
    parameter int STF_WIDTH = 24,
    parameter int RTF_WIDTH = 24,
    parameter int CMD_WIDTH = 8,
    parameter int DIF_WIDTH = CMD_WIDTH + STF_WIDTH,
    parameter int DLY_WIDTH = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    dut_vector_engine_if.master  bus,
    output logic                 busy,
    output logic                 cmd_err,
    output logic [CNT_WIDTH-1:0] vec_done
);
    localparam logic [CMD_WIDTH-1:0] CMD_NOP   = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] CMD_MUXES = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_DELAY = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] CMD_MASK  = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] CMD_RUN   = CMD_WIDTH'(4);

    typedef enum logic [2:0] {
        IDLE, DECODE, FETCH, CLK_HI, SETTLE, CAPTURE
    } state_t;

    state_t               state;
    logic [DIF_WIDTH-1:0] cmd_q;
    logic [STF_WIDTH-1:0] mosi_q;
    logic [STF_WIDTH-1:0] clk_sel;
    logic [STF_WIDTH-1:0] remaining;
    logic                 dut_clk_q;
    logic [RTF_WIDTH-1:0] resp_q;
    logic [RTF_WIDTH-1:0] mask;
    logic [DLY_WIDTH-1:0] dly;
    logic [DLY_WIDTH-1:0] settle_cnt;

    logic [CMD_WIDTH-1:0] cmd_code;
    logic [STF_WIDTH-1:0] payload;

    assign cmd_code = cmd_q[DIF_WIDTH-1 -: CMD_WIDTH];
    assign payload  = cmd_q[STF_WIDTH-1:0];

    // Strobes are gated by reset_n so nothing is acknowledged while reset is held.
    assign bus.dififo_rdreq = reset_n && (state == IDLE)    && !bus.dififo_rdempty;
    assign bus.sfifo_rdreq  = reset_n && (state == FETCH)   && !bus.sfifo_rdempty;
    assign bus.rfifo_wrreq  = reset_n && (state == CAPTURE) && !bus.rfifo_wrfull;
    assign bus.rfifo_data   = resp_q;
    assign bus.mosi_data    = (clk_sel & {STF_WIDTH{dut_clk_q}}) | (~clk_sel & mosi_q);
    assign busy             = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            cmd_q      <= '0;
            mosi_q     <= '0;
            clk_sel    <= '0;
            remaining  <= '0;
            dut_clk_q  <= 1'b0;
            resp_q     <= '0;
            mask       <= '1;
            dly        <= DLY_WIDTH'(1);
            settle_cnt <= '0;
            cmd_err    <= 1'b0;
            vec_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dififo_rdreq) begin
                        cmd_q <= bus.dififo_data;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    state <= IDLE;
                    case (cmd_code)
                        CMD_NOP:   ;
                        CMD_MUXES: clk_sel <= payload;
                        CMD_DELAY: dly     <= payload[DLY_WIDTH-1:0];
                        CMD_MASK:  mask    <= RTF_WIDTH'(payload);
                        CMD_RUN: begin
                            remaining <= payload;
                            if (payload != '0) state <= FETCH;
                        end
                        default:   cmd_err <= 1'b1;
                    endcase
                end
                FETCH: begin
                    if (bus.sfifo_rdreq) begin
                        mosi_q    <= bus.sfifo_data;
                        dut_clk_q <= 1'b0;
                        state     <= CLK_HI;
                    end
                end
                CLK_HI: begin
                    dut_clk_q  <= 1'b1;
                    settle_cnt <= (dly == '0) ? DLY_WIDTH'(1) : dly;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == DLY_WIDTH'(1)) begin
                        resp_q <= bus.miso_data & mask;
                        state  <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - DLY_WIDTH'(1);
                    end
                end
                CAPTURE: begin
                    if (bus.rfifo_wrreq) begin
                        remaining <= remaining - STF_WIDTH'(1);
                        vec_done  <= vec_done + CNT_WIDTH'(1);
                        state     <= (remaining == STF_WIDTH'(1)) ? IDLE : FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dut_vector_engine.sv
// tb/tb_dut_vector_engine.sv - directed table and sequence bench for dut_vector_engine
module tb_dut_vector_engine;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        busy;
    logic        cmd_err;
    logic [15:0] vec_done;
    logic        wrfull = 1'b0;

    dut_vector_engine_if #(.STF_WIDTH(24), .RTF_WIDTH(24), .DIF_WIDTH(32)) bus ();

    dut_vector_engine #(
        .STF_WIDTH(24), .RTF_WIDTH(24), .CMD_WIDTH(8), .DIF_WIDTH(32),
        .DLY_WIDTH(4), .CNT_WIDTH(16)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus.master),
        .busy(busy), .cmd_err(cmd_err), .vec_done(vec_done)
    );

    always #5 clock = ~clock;

    logic [23:0] stim_mem [64];
    logic [31:0] cmd_mem  [64];
    logic [23:0] wr_data  [64];
    int          wr_cyc   [64];
    int          sread_cyc[64];
    int stim_wr = 0, stim_rd = 0, cmd_wr = 0, cmd_rd = 0, wr_cnt = 0, cyc = 0;
    int n_checks = 0, n_pass = 0, exp_vd = 0;

    assign bus.sfifo_data     = stim_mem[stim_rd];
    assign bus.sfifo_rdempty  = (stim_rd == stim_wr);
    assign bus.dififo_data    = cmd_mem[cmd_rd];
    assign bus.dififo_rdempty = (cmd_rd == cmd_wr);
    assign bus.rfifo_wrfull   = wrfull;
    assign bus.miso_data      = bus.mosi_data;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.sfifo_rdreq) begin
            sread_cyc[stim_rd] <= cyc;
            stim_rd <= stim_rd + 1;
        end
        if (bus.dififo_rdreq) cmd_rd <= cmd_rd + 1;
        if (bus.rfifo_wrreq) begin
            wr_data[wr_cnt] <= bus.rfifo_data;
            wr_cyc[wr_cnt]  <= cyc;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    task automatic push_cmd(input logic [7:0] c, input logic [23:0] p);
        cmd_mem[cmd_wr] = {c, p};
        cmd_wr++;
    endtask

    task automatic push_stim(input logic [23:0] v);
        stim_mem[stim_wr] = v;
        stim_wr++;
    endtask

    task automatic wait_writes(input int n);
        int k = 0;
        while (wr_cnt < n && k < 2000) begin @(negedge clock); k++; end
        if (wr_cnt < n) fail_timeout("wait_writes");
    endtask

    task automatic wait_sreads(input int n);
        int k = 0;
        while (stim_rd < n && k < 2000) begin @(negedge clock); k++; end
        if (stim_rd < n) fail_timeout("wait_sreads");
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((cmd_rd != cmd_wr || busy) && k < 2000) begin @(negedge clock); k++; end
        if (cmd_rd != cmd_wr || busy) fail_timeout("wait_idle");
    endtask

    typedef struct {
        logic [23:0] mask;
        logic [23:0] dly;
        logic [23:0] sel;
        logic [23:0] stim;
        logic [23:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int s0, w0;
        bit hold_ok;

        tbl[0] = '{24'hFFFFFF, 24'd1,  24'h000000, 24'hA5A5A5, 24'hA5A5A5, 3};
        tbl[1] = '{24'h0000FF, 24'd1,  24'h000000, 24'h123456, 24'h000056, 3};
        tbl[2] = '{24'hFFFFFF, 24'd0,  24'h000000, 24'h00F0F0, 24'h00F0F0, 3};
        tbl[3] = '{24'hFFFFFF, 24'd3,  24'h000010, 24'h000000, 24'h000010, 5};
        tbl[4] = '{24'hF0F0F0, 24'd15, 24'h000001, 24'hFFFFFE, 24'hF0F0F0, 17};
        tbl[5] = '{24'h00FFFF, 24'd2,  24'h800000, 24'h0000AB, 24'h0000AB, 4};

        // Reset state, with a command already waiting
        push_cmd(8'h00, 24'h0);
        repeat (3) @(negedge clock);
        check("rst_dififo_rdreq", 32'(bus.dififo_rdreq), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_vec_done", 32'(vec_done), 32'd0);
        check("rst_mosi", 32'(bus.mosi_data), 32'd0);
        check("rst_wrreq", 32'(bus.rfifo_wrreq), 32'd0);
        reset_n = 1'b1;
        wait_idle();

        // Masked loopback burst of three
        w0 = wr_cnt;
        push_cmd(8'h03, 24'h0000FF);
        push_cmd(8'h04, 24'd3);
        push_stim(24'h000001); push_stim(24'h000002); push_stim(24'h000003);
        wait_writes(w0 + 3);
        exp_vd += 3;
        check("run3_d0", 32'(wr_data[w0]),     32'h1);
        check("run3_d1", 32'(wr_data[w0 + 1]), 32'h2);
        check("run3_d2", 32'(wr_data[w0 + 2]), 32'h3);
        check("run3_period", 32'(wr_cyc[w0 + 1] - wr_cyc[w0]), 32'd4);
        check("run3_busy_fell", 32'(busy), 32'd0);
        check("run3_vec_done", 32'(vec_done), 32'(exp_vd));

        // DUT clock on mosi[4], settle 3
        w0 = wr_cnt; s0 = stim_wr;
        push_cmd(8'h01, 24'h000010);
        push_cmd(8'h02, 24'd3);
        push_cmd(8'h04, 24'd2);
        push_stim(24'h000000); push_stim(24'h000020);
        wait_sreads(s0 + 1);
        check("mux_clk_low", 32'(bus.mosi_data[4]), 32'd0);
        @(negedge clock);
        check("mux_clk_high", 32'(bus.mosi_data[4]), 32'd1);
        wait_writes(w0 + 2);
        exp_vd += 2;
        check("mux_wr_latency", 32'(wr_cyc[w0] - sread_cyc[s0]), 32'd5);
        check("mux_period", 32'(sread_cyc[s0 + 1] - sread_cyc[s0]), 32'd6);
        check("mux_d0", 32'(wr_data[w0]), 32'h10);
        check("mux_d1", 32'(wr_data[w0 + 1]), 32'h30);
        wait_idle();

        // Table-driven single-vector runs
        for (int i = 0; i < 6; i++) begin
            w0 = wr_cnt; s0 = stim_wr;
            push_cmd(8'h03, tbl[i].mask);
            push_cmd(8'h02, tbl[i].dly);
            push_cmd(8'h01, tbl[i].sel);
            push_cmd(8'h04, 24'd1);
            push_stim(tbl[i].stim);
            wait_writes(w0 + 1);
            wait_idle();
            exp_vd += 1;
            check($sformatf("tbl%0d_data", i), 32'(wr_data[w0]), 32'(tbl[i].exp_data));
            check($sformatf("tbl%0d_latency", i), 32'(wr_cyc[w0] - sread_cyc[s0]), 32'(tbl[i].exp_lat));
            check($sformatf("tbl%0d_vec_done", i), 32'(vec_done), 32'(exp_vd));
        end

        // Result FIFO full for 4 cycles in the first CAPTURE
        push_cmd(8'h03, 24'hFFFFFF);
        push_cmd(8'h02, 24'd1);
        push_cmd(8'h01, 24'h000001);
        wait_idle();
        wrfull = 1'b1;
        w0 = wr_cnt; s0 = stim_wr;
        push_cmd(8'h04, 24'd2);
        push_stim(24'h000100); push_stim(24'h000200);
        wait_sreads(s0 + 1);
        repeat (5) @(negedge clock);
        check("full_clk_held", 32'(bus.mosi_data[0]), 32'd1);
        check("full_no_sread", 32'(stim_rd), 32'(s0 + 1));
        check("full_no_write", 32'(wr_cnt), 32'(w0));
        @(negedge clock);
        wrfull = 1'b0;
        wait_writes(w0 + 2);
        exp_vd += 2;
        check("full_wr_latency", 32'(wr_cyc[w0] - sread_cyc[s0]), 32'd7);
        check("full_d0", 32'(wr_data[w0]), 32'h000101);
        check("full_d1", 32'(wr_data[w0 + 1]), 32'h000201);
        check("full_lat2", 32'(wr_cyc[w0 + 1] - sread_cyc[s0 + 1]), 32'd3);
        wait_idle();

        // Stimulus FIFO empty for 5 cycles before the second vector
        push_cmd(8'h01, 24'h000000);
        wait_idle();
        w0 = wr_cnt; s0 = stim_wr;
        push_cmd(8'h04, 24'd2);
        push_stim(24'h00ABCD);
        wait_writes(w0 + 1);
        hold_ok = (bus.mosi_data == 24'h00ABCD);
        repeat (4) begin
            @(negedge clock);
            if (bus.mosi_data != 24'h00ABCD) hold_ok = 1'b0;
        end
        check("empty_mosi_held", 32'(hold_ok), 32'd1);
        push_stim(24'h001234);
        wait_writes(w0 + 2);
        wait_idle();
        exp_vd += 2;
        check("empty_fetch_wait", 32'(sread_cyc[s0 + 1] - wr_cyc[w0]), 32'd5);
        check("empty_d1", 32'(wr_data[w0 + 1]), 32'h001234);
        check("empty_two_writes", 32'(wr_cnt), 32'(w0 + 2));
        check("empty_vec_done", 32'(vec_done), 32'(exp_vd));

        // Unknown command then RUN 0
        w0 = wr_cnt; s0 = stim_rd;
        push_cmd(8'h7F, 24'h0);
        push_cmd(8'h04, 24'd0);
        wait_idle();
        check("bad_cmd_err", 32'(cmd_err), 32'd1);
        check("run0_no_sread", 32'(stim_rd), 32'(s0));
        check("run0_no_write", 32'(wr_cnt), 32'(w0));

        // Reset during SETTLE of a 5-vector burst
        push_cmd(8'h02, 24'd8);
        wait_idle();
        w0 = wr_cnt; s0 = stim_wr;
        push_cmd(8'h04, 24'd5);
        for (int i = 0; i < 5; i++) push_stim(24'h000040 + 24'(i));
        wait_sreads(s0 + 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd_err", 32'(cmd_err), 32'd0);
        check("midrst_vec_done", 32'(vec_done), 32'd0);
        check("midrst_mosi", 32'(bus.mosi_data), 32'd0);
        check("midrst_rfifo_data", 32'(bus.rfifo_data), 32'd0);
        check("midrst_sfifo_rdreq", 32'(bus.sfifo_rdreq), 32'd0);
        check("midrst_wrreq", 32'(bus.rfifo_wrreq), 32'd0);
        reset_n = 1'b1;
        repeat (30) @(negedge clock);
        check("midrst_no_write", 32'(wr_cnt), 32'(w0));
        check("midrst_no_sread", 32'(stim_rd), 32'(s0 + 1));
        check("midrst_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
